// File: rtl/ysyx_24110006_wb_scheduler.sv
// Writeback scheduler: round-robin share of the single RF write port between
// EXU (r0) and LSU (r1), plus a busy-register scoreboard for RAW/WAW stalls.
module ysyx_24110006_wb_scheduler #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NREG       = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_iss_valid,
  input  logic                  i_iss_wen,
  input  logic [ADDR_WIDTH-1:0] i_iss_rd,
  input  logic [ADDR_WIDTH-1:0] i_raddr1,
  input  logic [ADDR_WIDTH-1:0] i_raddr2,
  output logic                  o_iss_ready,
  input  logic                  i_r0_valid,
  input  logic [ADDR_WIDTH-1:0] i_r0_waddr,
  input  logic [DATA_WIDTH-1:0] i_r0_wdata,
  output logic                  o_r0_ready,
  input  logic                  i_r1_valid,
  input  logic [ADDR_WIDTH-1:0] i_r1_waddr,
  input  logic [DATA_WIDTH-1:0] i_r1_wdata,
  output logic                  o_r1_ready,
  output logic                  o_rf_valid,
  output logic                  o_rf_wen,
  output logic [ADDR_WIDTH-1:0] o_rf_waddr,
  output logic [DATA_WIDTH-1:0] o_rf_wdata,
  output logic [NREG-1:0]       o_busy
);

  localparam int unsigned IDX_W = 4;

  // Last-grant pointer states
  typedef enum logic {
    LAST_R0 = 1'b0,
    LAST_R1 = 1'b1
  } last_e;

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  // Address bit 4 aliases onto the low 16 registers, as in the register file
  logic unused_addr_hi;
  assign unused_addr_hi = ^{i_iss_rd[ADDR_WIDTH-1:IDX_W],
                            i_raddr1[ADDR_WIDTH-1:IDX_W],
                            i_raddr2[ADDR_WIDTH-1:IDX_W]};

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  logic            raw;
  logic            waw;
  logic            iss_fire;

  last_e           last_q;
  last_e           last_d;
  logic            grant0;
  logic            grant1;
  logic            any_grant;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Hazard detection against the current scoreboard
  always_comb begin
    raw = ((idx(i_raddr1) != '0) && busy_q[idx(i_raddr1)]) ||
          ((idx(i_raddr2) != '0) && busy_q[idx(i_raddr2)]);
    waw = i_iss_wen && (idx(i_iss_rd) != '0) && busy_q[idx(i_iss_rd)];
  end

  assign o_iss_ready = !(raw || waw);
  assign iss_fire    = i_iss_valid && o_iss_ready && i_iss_wen && (idx(i_iss_rd) != '0);

  // Scoreboard update; a forced same-index set and clear resolves to set
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_fire) begin
      set_mask = NREG'(1) << idx(i_iss_rd);
    end
    if (o_rf_valid && (idx(o_rf_waddr) != '0)) begin
      clr_mask = NREG'(1) << idx(o_rf_waddr);
    end
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign o_busy = busy_q;

  // Round-robin pointer: state register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      last_q <= LAST_R1;
    end else begin
      last_q <= last_d;
    end
  end

  // Round-robin pointer: next state moves only on an accepted transfer
  always_comb begin
    last_d = last_q;
    if (grant0) begin
      last_d = LAST_R0;
    end else if (grant1) begin
      last_d = LAST_R1;
    end
  end

  // Round-robin pointer: grant outputs
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (i_r0_valid && i_r1_valid) begin
      grant0 = (last_q == LAST_R1);
      grant1 = (last_q == LAST_R0);
    end else begin
      grant0 = i_r0_valid;
      grant1 = i_r1_valid;
    end
  end

  assign o_r0_ready = grant0;
  assign o_r1_ready = grant1;
  assign any_grant  = grant0 || grant1;
  assign sel_addr   = grant1 ? i_r1_waddr : i_r0_waddr;
  assign sel_data   = grant1 ? i_r1_wdata : i_r0_wdata;

  // Registered RF write port; address and data hold when idle
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_rf_valid <= 1'b0;
      o_rf_wen   <= 1'b0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
    end else if (any_grant) begin
      o_rf_valid <= 1'b1;
      o_rf_wen   <= (idx(sel_addr) != '0);
      o_rf_waddr <= sel_addr;
      o_rf_wdata <= sel_data;
    end else begin
      o_rf_valid <= 1'b0;
      o_rf_wen   <= 1'b0;
    end
  end

endmodule
